// File: rtl/pc_controller.sv
// Run/halt sequencer that steers the program counter's jump/increment inputs.
// Define PC_CALL_STACK_EN to add the call/return address stack.
module pc_controller #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             branch_req,
    input  logic [PC_W-1:0]  branch_offset,
    input  logic             call_req,
    input  logic             ret_req,
    output logic             jumpEnable,
    output logic [PC_W-1:0]  jump,
    output logic             running,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t state, state_nx;
    logic retire;
    logic stk_err;
    logic push, pop;
    logic cl, rt;
    logic full, empty;
    logic [PC_W-1:0] top;

`ifdef PC_CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0] sp;
    logic            err_q;

    assign cl    = call_req;
    assign rt    = ret_req;
    assign full  = (sp == SP_W'(STACK_DEPTH));
    assign empty = (sp == '0);
    assign top   = stack[IDX_W'(sp - SP_W'(1))];
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (push)
            stack[IDX_W'(sp)] <= pc + PC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else begin
            if (push)
                sp <= sp + SP_W'(1);
            else if (pop)
                sp <= sp - SP_W'(1);
            if (stk_err)
                err_q <= 1'b1;
        end
    end
`else
    // Call/return are disabled: requests are masked off and err stays low.
    assign cl    = call_req & 1'b0;
    assign rt    = ret_req & 1'b0;
    assign full  = 1'b0;
    assign empty = 1'b0;
    assign top   = pc;
    assign err   = 1'b0 & (push | pop | stk_err);
`endif

    always_comb begin
        state_nx   = state;
        jumpEnable = 1'b1;
        jump       = '0;
        retire     = 1'b0;
        stk_err    = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = RUN;
            end
            RUN: begin
                if (stall) begin
                    retire = 1'b0;
                end else if (halt_req) begin
                    retire   = 1'b1;
                    state_nx = HALT;
                end else if (rt) begin
                    if (empty) begin
                        stk_err  = 1'b1;
                        state_nx = HALT;
                    end else begin
                        jump   = top - pc;
                        pop    = 1'b1;
                        retire = 1'b1;
                    end
                end else if (cl) begin
                    if (full) begin
                        stk_err  = 1'b1;
                        state_nx = HALT;
                    end else begin
                        jump   = branch_offset;
                        push   = 1'b1;
                        retire = 1'b1;
                    end
                end else if (branch_req) begin
                    jump   = branch_offset;
                    retire = 1'b1;
                end else begin
                    jumpEnable = 1'b0;
                    retire     = 1'b1;
                end
            end
            HALT: begin
                state_nx = HALT;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Reset forces a hold so the counter never steps on a reset edge.
        if (reset) begin
            jumpEnable = 1'b1;
            jump       = '0;
            push       = 1'b0;
            pop        = 1'b0;
            stk_err    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
            retired <= '0;
        end else begin
            state   <= state_nx;
            running <= (state_nx == RUN);
            done    <= (state_nx == HALT);
            if (retire && !(&retired))
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_controller.sv
// Directed plus randomized bench for pc_controller with an abstract PC model.
// Call/return scenarios are exercised when PC_CALL_STACK_EN is defined.
module tb_pc_controller;

    localparam int PW = 8;
    localparam int SD = 4;
    localparam int CW = 5;
`ifdef PC_CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, stall, halt_req, branch_req, call_req, ret_req;
    logic [PW-1:0] branch_offset;
    logic [PW-1:0] pc;
    logic jumpEnable;
    logic [PW-1:0] jump;
    logic running, done, err;
    logic [CW-1:0] retired;

    int checks = 0;
    int failures = 0;

    int m_mode;
    int m_pc = 0;
    int m_ret;
    bit m_err;
    int m_stk[$];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (reset)
            pc <= '0;
        else
            pc <= pc + (jumpEnable ? jump : 8'd1);
    end

    pc_controller #(
        .PC_W(PW),
        .STACK_DEPTH(SD),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pc(pc),
        .stall(stall),
        .halt_req(halt_req),
        .branch_req(branch_req),
        .branch_offset(branch_offset),
        .call_req(call_req),
        .ret_req(ret_req),
        .jumpEnable(jumpEnable),
        .jump(jump),
        .running(running),
        .done(done),
        .err(err),
        .retired(retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit st, input bit stl,
                       input bit hr, input bit br, input bit cl,
                       input bit rt, input logic [7:0] off);
        int npc;
        bit adv;
        reset = rst; start = st; stall = stl; halt_req = hr;
        branch_req = br; call_req = cl; ret_req = rt;
        branch_offset = off;
        #1;
        npc = m_pc;
        adv = 1'b0;
        if (rst) begin
            chk("rst_je", 32'(jumpEnable), 1);
            chk("rst_jump", 32'(jump), 0);
            m_mode = 0; npc = 0; m_ret = 0; m_err = 0;
            m_stk.delete();
        end else begin
            if (m_mode == 0) begin
                if (st) m_mode = 1;
            end else if (m_mode == 1 && !stl) begin
                if (hr) begin
                    adv = 1'b1; m_mode = 2;
                end else if (STK && rt) begin
                    if (m_stk.size() == 0) begin
                        m_err = 1; m_mode = 2;
                    end else begin
                        npc = m_stk.pop_back(); adv = 1'b1;
                    end
                end else if (STK && cl) begin
                    if (m_stk.size() == SD) begin
                        m_err = 1; m_mode = 2;
                    end else begin
                        m_stk.push_back((m_pc + 1) % 256);
                        npc = (m_pc + int'(off)) % 256; adv = 1'b1;
                    end
                end else if (br) begin
                    npc = (m_pc + int'(off)) % 256; adv = 1'b1;
                end else begin
                    npc = (m_pc + 1) % 256; adv = 1'b1;
                end
            end
            if (adv && m_ret < (1 << CW) - 1) m_ret++;
            chk("step", 32'(8'(pc + (jumpEnable ? jump : 8'd1))), npc);
        end
        m_pc = npc;
        @(posedge clk);
        @(negedge clk);
        chk("pc", 32'(pc), m_pc);
        chk("running", 32'(running), 32'(m_mode == 1));
        chk("done", 32'(done), 32'(m_mode == 2));
        chk("err", 32'(err), 32'(m_err));
        chk("retired", 32'(retired), m_ret);
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) begin
            reset = 0; start = 0; stall = 0; halt_req = 0;
            branch_req = 0; call_req = 0; ret_req = 0;
            #1;
            chk("inc_je", 32'(jumpEnable), 0);
            cyc(0, 0, 0, 0, 0, 0, 0, 8'h00);
        end
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
        #1;
        chk("idle_je", 32'(jumpEnable), 1);
        chk("idle_jump", 32'(jump), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
        chk("start_pc", 32'(pc), 0);
        plain(5);
        chk("run5_pc", 32'(pc), 5);
        chk("run5_ret", 32'(retired), 5);

        cyc(0, 0, 0, 0, 1, 0, 0, 8'h04);
        chk("br_fwd", 32'(pc), 9);
        cyc(0, 0, 0, 0, 1, 0, 0, 8'hFC);
        chk("br_back", 32'(pc), 5);
        cyc(0, 0, 0, 0, 1, 0, 0, 8'h04);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1, 0, 1, 0, 0, 8'h04);
        chk("stall_pc", 32'(pc), 9);
        chk("stall_ret", 32'(retired), 8);
        cyc(0, 0, 0, 0, 1, 0, 0, 8'h04);
        chk("post_stall", 32'(pc), 13);
        cyc(0, 0, 0, 0, 1, 0, 0, 8'hF1);
        chk("to_fe", 32'(pc), 8'hFE);
        cyc(0, 0, 0, 0, 1, 0, 0, 8'h05);
        chk("wrap", 32'(pc), 3);
        cyc(0, 0, 0, 0, 1, 0, 0, 8'h00);
        chk("spin", 32'(pc), 3);
        plain(4);
        cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
        chk("halt_pc", 32'(pc), 7);
        chk("halt_done", 32'(done), 1);
        cyc(0, 1, 0, 0, 1, 0, 0, 8'h09);
        chk("halt_start", 32'(pc), 7);
        cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
        chk("rst_ret", 32'(retired), 0);
        chk("rst_run", 32'(running), 0);

`ifdef PC_CALL_STACK_EN
        cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
        plain(3);
        cyc(0, 0, 0, 0, 0, 1, 0, 8'h0A);
        chk("call", 32'(pc), 13);
        cyc(0, 0, 0, 0, 0, 0, 1, 8'h00);
        chk("ret", 32'(pc), 4);
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 0, 0, 0, 1, 0, 8'h01);
        chk("ovf_pc", 32'(pc), 8);
        chk("ovf_err", 32'(err), 1);
        chk("ovf_done", 32'(done), 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 0, 0, 1, 8'h00);
        chk("unf_err", 32'(err), 1);
        chk("unf_pc", 32'(pc), 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
        chk("err_clr", 32'(err), 0);
`endif

        cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 1, 0, 0, 8'd20);
        chk("pc20", 32'(pc), 20);
        cyc(1, 0, 0, 0, 1, 0, 0, 8'h07);
        #1;
        chk("mid_je", 32'(jumpEnable), 1);
        chk("mid_jump", 32'(jump), 0);
        chk("mid_run", 32'(running), 0);
        chk("mid_pc", 32'(pc), 0);

        cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
        plain(35);
        chk("sat", 32'(retired), 31);
        cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
        chk("sat_halt", 32'(retired), 31);

        for (int ep = 0; ep < 20; ep++) begin
            cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
            cyc(0, 0, 0, 0, 1, 1, 1, 8'h00);
            cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
            for (int c = 0; c < 60; c++) begin
                cyc(0, $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 12,
                    $urandom_range(0, 99) < 12,
                    8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_controller.md
# pc_controller

Sequencer for the 8-bit program counter. Each cycle it chooses the PC's step: increment, relative branch, hold, or (optionally) call/return. It does this by driving the counter's `jumpEnable`/`jump` inputs. It sits between instruction decode and the program counter and owns run/halt control for the core.

## Interface
Parameters:
- `PC_W`, default 8: program-counter and offset width.
- `STACK_DEPTH`, default 4: return-address stack entries (used only with `PC_CALL_STACK_EN`).
- `CNT_W`, default 16: retired-instruction counter width.

Ports:
- `clk` in 1: clock. One clock domain; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin execution; sampled only in IDLE.
- `pc` in PC_W: current counter value (`count` from the program counter).
- `stall` in 1: memory/decode not ready; hold PC this cycle.
- `halt_req` in 1: decoded instruction is HALT.
- `branch_req` in 1: taken branch this cycle.
- `branch_offset` in PC_W: two's-complement relative offset for a branch or call.
- `call_req` in 1: CALL instruction (macro only; ignored otherwise).
- `ret_req` in 1: RET instruction (macro only; ignored otherwise).
- `jumpEnable` out 1: to program counter; 1 selects `jump` as the step.
- `jump` out PC_W: step added to PC (mod 2^PC_W) when `jumpEnable`=1.
- `running` out 1: state is RUN.
- `done` out 1: state is HALT.
- `err` out 1: sticky stack overflow/underflow flag.
- `retired` out CNT_W: count of instructions retired since reset.

## Operation
- Program-counter contract: `pc` at edge n+1 = `pc` + (`jumpEnable` ? `jump` : 1), all mod 2^PC_W. Hold is encoded as `jumpEnable`=1, `jump`=0.
- `jumpEnable`/`jump` are combinational from state and current inputs. The counter consumes them at the same edge.
- States and transitions:
  - IDLE: hold PC. `start`=1 -> RUN.
  - RUN: advance per the priority list below. `halt_req` (and not `stall`) -> HALT. Stack error -> HALT with `err`=1.
  - HALT: hold PC; `done`=1. Exits only on `reset`.
- RUN priority, one action per cycle:
  1. `stall`: hold; no retire.
  2. `halt_req`: hold; retire; go to HALT.
  3. `ret_req`: jump = top − `pc`; pop.
  4. `call_req`: push `pc`+1; jump = `branch_offset`.
  5. `branch_req`: jump = `branch_offset`.
  6. Otherwise: `jumpEnable`=0 (increment).
- `retired` increments by 1 on every non-stall RUN cycle, including the HALT instruction. It saturates at all-ones.
- Offset 0 on a branch is legal and spins on the same PC. Wrap-around (e.g. 0xFE + 5 = 0x03) is legal and not an error.
- Reset in any state, mid-operation included: takes effect at that edge and overrides all other inputs.

## Timing
- Reset values: state IDLE, `jumpEnable`=1, `jump`=0, `running`=0, `done`=0, `err`=0, `retired`=0, stack pointer 0.
- `start` asserted at edge k -> RUN from edge k; the first PC advance occurs at edge k+1.
- `halt_req` at edge k -> PC unchanged at k; `done`=1 after edge k.
- `running`, `done`, `err`, and `retired` are registered and update one edge after the causing event.
- Branch, call, and return latency: zero bubbles. The new PC appears after the same edge.

## Configuration
- `PC_CALL_STACK_EN` defined:
  - Includes a STACK_DEPTH × PC_W return-address stack and honours `call_req`/`ret_req`.
  - Push when full, or pop when empty: PC holds, no retire, `err`=1, go to HALT.
- Not defined:
  - No stack storage; `call_req`/`ret_req` are ignored (treated as 0).
  - `err` is tied to 0.

## Test plan
- Reset then `start`; no requests for 5 cycles -> `pc` 0→5, `retired`=5, `jumpEnable`=0 throughout RUN.
- From `pc`=5, `branch_req` with offset 4 -> `pc`=9. Then offset 0xFC (−4) -> `pc`=5. Separately, `pc`=0xFE with offset 5 -> 0x03.
- `stall` and `branch_req` both high for 3 cycles at `pc`=9 -> `pc` stays 9 and `retired` unchanged; branch taken on the first non-stall cycle.
- `halt_req` at `pc`=7 -> `pc` stays 7, `done`=1 next cycle. Later `start` ignored; `reset` returns to IDLE with `retired`=0.
- With macro: call at `pc`=3, offset 10 -> `pc`=13. `ret_req` -> `pc`=4. Five nested calls with depth 4 -> fifth holds PC, `err`=1, `done`=1.
- `reset` asserted mid-branch at `pc`=20 -> the next cycle shows IDLE outputs (`jumpEnable`=1, `jump`=0, `running`=0).
